// File: rtl/accum_stage.sv
// Neuron accumulation stage: two-level registered adder tree over 28 product lanes,
// accumulated across BEATS valid beats plus a per-neuron bias.
module accum_stage #(
  parameter int unsigned LANES  = 28,
  parameter int unsigned PROD_W = 26,
  parameter int unsigned BEATS  = 28,
  parameter int unsigned BIAS_W = 26,
  parameter int unsigned ACC_W  = 36,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                       clk,
  input  logic                       GlobalReset,
  input  logic                       in_valid,
  input  logic [LANES*PROD_W-1:0]    Output_syn,
  input  logic signed [BIAS_W-1:0]   bias,
  input  logic                       clear,
  output logic                       out_valid,
  output logic signed [ACC_W-1:0]    out_sum,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       busy
);

  localparam int unsigned GROUPS    = 4;
  localparam int unsigned GRP_LANES = 7;
  localparam int unsigned GRP_W     = PROD_W + 3;
  localparam int unsigned TOT_W     = GRP_W + 2;
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]         beat_q, beat_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_first_q, s1_first_d;
  logic                     s1_last_q, s1_last_d;
  logic signed [BIAS_W-1:0] s1_bias_q, s1_bias_d;
  logic signed [GRP_W-1:0]  grp_q [GROUPS];
  logic signed [GRP_W-1:0]  grp_d [GROUPS];
  logic signed [GRP_W-1:0]  grp_sum_c [GROUPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         nidx_q, nidx_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [IDX_W-1:0]         out_idx_q, out_idx_d;
  logic                     busy_q, busy_d;

  logic                     take_c;
  logic                     fire_c;
  logic                     first_beat_c;
  logic signed [TOT_W-1:0]  total_c;
  logic signed [ACC_W-1:0]  base_c;
  logic signed [ACC_W-1:0]  sum_c;

  // First tree level: sign-extended sum of each 7-lane group
  always_comb begin
    for (int g = 0; g < int'(GROUPS); g++) begin
      grp_sum_c[g] = '0;
      for (int j = 0; j < int'(GRP_LANES); j++) begin
        grp_sum_c[g] = grp_sum_c[g]
                     + GRP_W'($signed(Output_syn[PROD_W*(GRP_LANES*g+j) +: PROD_W]));
      end
    end
  end

  // Second tree level and accumulate; first beat seeds from bias instead of acc
  always_comb begin
    total_c = '0;
    for (int g = 0; g < int'(GROUPS); g++) begin
      total_c = total_c + TOT_W'(grp_q[g]);
    end
    base_c = s1_first_q ? ACC_W'(s1_bias_q) : acc_q;
    sum_c  = base_c + ACC_W'(total_c);
  end

  always_comb begin
    take_c       = in_valid & ~clear;
    fire_c       = s1_valid_q & ~clear;
    first_beat_c = (beat_q == '0);

    beat_d      = beat_q;
    s1_valid_d  = take_c;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_bias_d   = s1_bias_q;
    acc_d       = acc_q;
    nidx_d      = nidx_q;
    out_valid_d = 1'b0;
    out_sum_d   = out_sum_q;
    out_idx_d   = out_idx_q;
    for (int g = 0; g < int'(GROUPS); g++) begin
      grp_d[g] = grp_q[g];
    end

    if (clear) begin
      beat_d = '0;
    end else if (in_valid) begin
      beat_d = (beat_q == CNT_W'(BEATS - 1)) ? '0 : beat_q + CNT_W'(1);
    end

    if (take_c) begin
      s1_first_d = first_beat_c;
      s1_last_d  = (beat_q == CNT_W'(BEATS - 1));
      if (first_beat_c) begin
        s1_bias_d = bias;
      end
      for (int g = 0; g < int'(GROUPS); g++) begin
        grp_d[g] = grp_sum_c[g];
      end
    end

    if (clear) begin
      acc_d = '0;
    end else if (fire_c) begin
      acc_d = sum_c;
      if (s1_last_q) begin
        out_valid_d = 1'b1;
        out_sum_d   = sum_c;
        out_idx_d   = nidx_q;
        nidx_d      = nidx_q + IDX_W'(1);
      end
    end

    busy_d = (beat_d != '0) | s1_valid_d;
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      beat_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_bias_q   <= '0;
      acc_q       <= '0;
      nidx_q      <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      for (int g = 0; g < int'(GROUPS); g++) begin
        grp_q[g] <= '0;
      end
    end else begin
      beat_q      <= beat_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_bias_q   <= s1_bias_d;
      acc_q       <= acc_d;
      nidx_q      <= nidx_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      for (int g = 0; g < int'(GROUPS); g++) begin
        grp_q[g] <= grp_d[g];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_accum_stage.sv
// Directed self-checking bench for accum_stage; outputs are collected at negedge
// and compared against hand-computed neuron sums.
module tb_accum_stage;
  localparam int unsigned LANES  = 28;
  localparam int unsigned PROD_W = 26;
  localparam int unsigned BEATS  = 28;
  localparam int unsigned BIAS_W = 26;
  localparam int unsigned ACC_W  = 36;
  localparam int unsigned IDX_W  = 8;

  logic                     clk = 1'b0;
  logic                     GlobalReset;
  logic                     in_valid;
  logic [LANES*PROD_W-1:0]  Output_syn;
  logic signed [BIAS_W-1:0] bias;
  logic                     clear;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_sum;
  logic [IDX_W-1:0]         out_idx;
  logic                     busy;

  int    n_checks = 0;
  int    n_fail   = 0;
  longint q_sum [$];
  longint q_idx [$];
  int    exp_idx;

  accum_stage #(
    .LANES(LANES), .PROD_W(PROD_W), .BEATS(BEATS),
    .BIAS_W(BIAS_W), .ACC_W(ACC_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid),
    .Output_syn(Output_syn), .bias(bias), .clear(clear),
    .out_valid(out_valid), .out_sum(out_sum), .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every output pulse mid-cycle
  always @(negedge clk) begin
    if (out_valid) begin
      q_sum.push_back(longint'(out_sum));
      q_idx.push_back(longint'(out_idx));
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes_const(input longint v);
    for (int k = 0; k < int'(LANES); k++) Output_syn[k*PROD_W +: PROD_W] = PROD_W'(v);
  endtask

  task automatic lanes_index();
    for (int k = 0; k < int'(LANES); k++) Output_syn[k*PROD_W +: PROD_W] = PROD_W'(k);
  endtask

  // Bias is only valid on the first beat; later beats carry junk bias
  task automatic run_neuron(input longint bv, input bit gaps);
    for (int b = 0; b < int'(BEATS); b++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      in_valid = 1'b1;
      bias = (b == 0) ? BIAS_W'(bv) : BIAS_W'(12345);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_outputs(input string tag, input int n);
    repeat (3) tick();
    check({tag, "_count"}, longint'(q_sum.size()), longint'(n));
  endtask

  task automatic pop_check(input string tag, input longint exp_sum);
    if (q_sum.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      check({tag, "_sum"}, q_sum.pop_front(), exp_sum);
      check({tag, "_idx"}, q_idx.pop_front(), longint'(exp_idx % 256));
      exp_idx++;
    end
  endtask

  initial begin
    GlobalReset = 1'b0;
    in_valid    = 1'b0;
    clear       = 1'b0;
    bias        = '0;
    Output_syn  = '0;
    exp_idx     = 0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_sum",   longint'(out_sum), 0);
    check("rst_out_idx",   longint'(out_idx), 0);
    check("rst_busy",      longint'(busy), 0);
    tick(); tick();
    GlobalReset = 1'b1;
    tick();

    // Sum check with explicit latency: pulse in the second cycle after the last beat
    lanes_const(1);
    run_neuron(0, 1'b0);
    check("lat_busy", longint'(busy), 1);
    check("lat_early", longint'(out_valid), 0);
    tick();
    check("lat_pulse", longint'(out_valid), 1);
    check("lat_sum", longint'(out_sum), 784);
    check("lat_idx", longint'(out_idx), 0);
    tick();
    check("lat_drop", longint'(out_valid), 0);
    check("lat_idle", longint'(busy), 0);
    check("lat_count", longint'(q_sum.size()), 1);
    pop_check("sum1", 784);

    // Extremes
    lanes_const(-(longint'(1) <<< 25));
    run_neuron(-(longint'(1) <<< 25), 1'b0);
    expect_outputs("ext_neg", 1);
    pop_check("ext_neg", -64'sd26340229120);
    lanes_const((longint'(1) <<< 25) - 1);
    run_neuron(0, 1'b0);
    expect_outputs("ext_pos", 1);
    pop_check("ext_pos", 784 * ((longint'(1) <<< 25) - 1));

    // Random gaps, then back-to-back neuron
    lanes_index();
    run_neuron(5, 1'b1);
    run_neuron(-5, 1'b0);
    expect_outputs("b2b", 2);
    pop_check("gap", 10589);
    pop_check("b2b", 10579);

    // Clear together with beat 10
    lanes_const(1);
    in_valid = 1'b1;
    bias = '0;
    repeat (9) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_busy", longint'(busy), 0);
    expect_outputs("clr_none", 0);
    check("clr_hold_sum", longint'(out_sum), 10579);
    run_neuron(0, 1'b0);
    expect_outputs("clr_next", 1);
    pop_check("clr_next", 784);

    // Asynchronous reset after beat 15
    lanes_const(2);
    in_valid = 1'b1;
    bias = BIAS_W'(3);
    repeat (15) tick();
    check("pre_rst_busy", longint'(busy), 1);
    #2;
    GlobalReset = 1'b0;
    #1;
    check("arst_out_valid", longint'(out_valid), 0);
    check("arst_out_sum",   longint'(out_sum), 0);
    check("arst_out_idx",   longint'(out_idx), 0);
    check("arst_busy",      longint'(busy), 0);
    in_valid = 1'b0;
    tick(); tick();
    GlobalReset = 1'b1;
    tick();
    check("arst_none", longint'(q_sum.size()), 0);
    exp_idx = 0;
    run_neuron(3, 1'b0);
    expect_outputs("arst_next", 1);
    pop_check("arst_next", 1571);

    // Index wrap over 256 continuous neurons
    lanes_const(0);
    for (int n = 0; n < 256; n++) run_neuron(longint'(n), 1'b0);
    expect_outputs("wrap", 256);
    for (int n = 0; n < 256; n++) pop_check("wrap", longint'(n));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
